bit_index_scan: RTL and testbench



---
 rtl/bit_manip_pkg.sv | 11 +
 rtl/bit_prio_enc.sv | 41 ++++
 rtl/bit_index_scan.sv | 108 ++++++++++
 tb/tb_bit_index_scan.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_manip_pkg.sv
// rtl/bit_manip_pkg.sv - shared state encoding and width default for the bit-manipulation blocks
package bit_manip_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_prio_enc.sv
// rtl/bit_prio_enc.sv - combinational set-bit priority encoder returning index and remaining mask
// BIT_SCAN_MSB_FIRST_EN adds msb_first to select the highest set bit instead of the lowest.
module bit_prio_enc
  import bit_manip_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
`ifdef BIT_SCAN_MSB_FIRST_EN
  input  logic             msb_first,
`endif
  output logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] rest
);

  logic [IDX_W-1:0] lo_idx;
`ifdef BIT_SCAN_MSB_FIRST_EN
  logic [IDX_W-1:0] hi_idx;
`endif

  always_comb begin
    // Descending walk so the last hit, which wins, is the lowest set bit.
    lo_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) lo_idx = IDX_W'(i);
    end
`ifdef BIT_SCAN_MSB_FIRST_EN
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) hi_idx = IDX_W'(i);
    end
    index = msb_first ? hi_idx : lo_idx;
`else
    index = lo_idx;
`endif
    rest = mask;
    rest[index] = 1'b0;
  end

endmodule

// File: rtl/bit_index_scan.sv
// rtl/bit_index_scan.sv - turns a word into a stream of its set-bit indices, one per beat
// BIT_SCAN_MSB_FIRST_EN adds a msb_first input, latched per word, for descending order.
module bit_index_scan
  import bit_manip_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
`ifdef BIT_SCAN_MSB_FIRST_EN
  input  logic             msb_first,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   out_count,
  output logic             out_last,
  output logic             out_none
);

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] enc_in;
  logic [WIDTH-1:0] enc_rest;
  logic [IDX_W-1:0] enc_idx;

  // In IDLE the encoder looks straight at the incoming word so the first beat costs no extra cycle.
  assign enc_in   = (state == IDLE) ? in_word : mask;
  assign in_ready = enable && (state == IDLE);

`ifdef BIT_SCAN_MSB_FIRST_EN
  logic dir_q;
  logic enc_dir;
  assign enc_dir = (state == IDLE) ? msb_first : dir_q;
`endif

  bit_prio_enc #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_enc (
    .mask     (enc_in),
`ifdef BIT_SCAN_MSB_FIRST_EN
    .msb_first(enc_dir),
`endif
    .index    (enc_idx),
    .rest     (enc_rest)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mask      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
`ifdef BIT_SCAN_MSB_FIRST_EN
      dir_q     <= 1'b0;
`endif
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
            dir_q <= msb_first;
`endif
            state     <= EMIT;
            out_valid <= 1'b1;
            if (in_word == '0) begin
              mask      <= '0;
              out_index <= '0;
              out_count <= '0;
              out_last  <= 1'b1;
              out_none  <= 1'b1;
            end else begin
              mask      <= enc_rest;
              out_index <= enc_idx;
              out_count <= (IDX_W + 1)'(1);
              out_last  <= (enc_rest == '0);
              out_none  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              mask      <= enc_rest;
              out_index <= enc_idx;
              out_count <= out_count + (IDX_W + 1)'(1);
              out_last  <= (enc_rest == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_index_scan.sv
// tb/tb_bit_index_scan.sv - randomized scoreboard bench for bit_index_scan
module tb_bit_index_scan;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_count;
  logic             out_last;
  logic             out_none;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_index_scan #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
`ifdef BIT_SCAN_MSB_FIRST_EN
    .msb_first(msb_first),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_count(out_count),
    .out_last (out_last),
    .out_none (out_none)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list of set-bit positions in scan order, straight from the word.
  function automatic void expected_order(input logic [WIDTH-1:0] w, input bit msb, output int q[$]);
    q = {};
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) begin
        if (msb) q.push_front(i);
        else q.push_back(i);
      end
    end
  endfunction

  // Sends one word and consumes its beats. stop_after >= 0 abandons the scan after that many beats.
  task automatic run_word(input logic [WIDTH-1:0] w, input bit msb, input int stall_pct,
                          input int en_pct, input int stall_beat, input int stop_after);
    int  q[$];
    int  n, beats, emitted, guard, stall_cnt;
    bit  eff_msb;
    bit  acc;
`ifdef BIT_SCAN_MSB_FIRST_EN
    eff_msb = msb;
`else
    eff_msb = 1'b0;
`endif
    expected_order(w, eff_msb, q);
    n     = q.size();
    beats = (n == 0) ? 1 : n;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_word   = w;
    msb_first = msb;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_word   = $urandom;
    msb_first = $urandom_range(1);
    emitted   = 0;
    guard     = 0;
    stall_cnt = 0;
    while (emitted < beats && guard < 400) begin
      guard++;
      if (stop_after >= 0 && emitted == stop_after) begin
        out_ready = 1'b0;
        return;
      end
      if (emitted == stall_beat && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      enable = ($urandom_range(99) < en_pct);
      @(negedge clk);
      check("out_valid", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      if (n == 0) begin
        check("none_flag", out_none, 1);
        check("none_index", out_index, 0);
        check("none_count", out_count, 0);
        check("none_last", out_last, 1);
      end else begin
        check("index", out_index, q[emitted]);
        check("count", out_count, emitted + 1);
        check("last", out_last, emitted == n - 1);
        check("none_clear", out_none, 0);
      end
      acc = out_ready && enable;
      @(posedge clk);
      #1;
      if (acc) emitted++;
    end
    out_ready = 1'b0;
    enable    = 1'b1;
    if (emitted < beats) begin
      check("beat_timeout", emitted, beats);
      return;
    end
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst       = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    msb_first = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_index", out_index, 0);
    check("rst_count", out_count, 0);
    check("rst_last", out_last, 0);
    check("rst_none", out_none, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;

    run_word(32'h0000_0000, 1'b0, 0, 100, -1, -1);
    run_word(32'h8000_0011, 1'b0, 0, 100, -1, -1);
    run_word(32'h8000_0011, 1'b0, 0, 100, 1, -1);
    run_word(32'hFFFF_FFFF, 1'b0, 0, 100, -1, -1);
    run_word(32'h8000_0011, 1'b1, 0, 100, -1, -1);
    run_word(32'h8000_0011, 1'b0, 0, 50, -1, -1);

    // Abandon after beats 0 and 4 and reset; index 31 must never show up.
    run_word(32'h8000_0011, 1'b0, 0, 100, -1, 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_index", out_index, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_none", out_none, 0);
    check("mid_rst_in_ready", in_ready, 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    out_ready = 1'b0;

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(4))
        0: w = $urandom & $urandom & $urandom;
        1: w = $urandom | $urandom;
        2: w = 32'h1 << $urandom_range(31);
        3: w = (k % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
        default: w = $urandom;
      endcase
      run_word(w, $urandom_range(1), 30, 80, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
